// File: rtl/jump_kinematics_pkg.sv
// rtl/jump_kinematics_pkg.sv - shared state encoding and saturation helpers for the jump integrator
package jump_kinematics_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RISE = 3'd1,
    ST_FALL = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int unsigned HOLD_CNT_W = 8;

  // Unsigned add that pins at max instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/jump_kinematics_tick_prescaler.sv
// rtl/jump_kinematics_tick_prescaler.sv - free-running physics tick divider with synchronous clear
module jump_kinematics_tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    o_tick = (cnt_q == LAST);
    cnt_d  = cnt_q + CNT_W'(1);
    if (i_clear || o_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/jump_kinematics.sv
// rtl/jump_kinematics.sv - projectile integrator producing per-tick height/distance and apex/land events
// Optional apex freeze enabled by defining JUMP_APEX_HOLD_EN.
module jump_kinematics
  import jump_kinematics_pkg::*;
#(
  parameter int unsigned V_W       = 11,
  parameter int unsigned H_W       = 9,
  parameter int unsigned D_W       = 11,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned VX        = 1,
  parameter int unsigned TICK_DIV  = 262144,
  parameter int unsigned APEX_HOLD = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_abort,
  input  logic [V_W-1:0] i_v_init,
  output logic [H_W-1:0] o_height,
  output logic [D_W-1:0] o_dist,
  output logic           o_busy,
  output logic           o_apex,
  output logic           o_land,
  output logic           o_done
);

  localparam int unsigned VY_W  = V_W + 1;
  // Wide enough that height + vy cannot wrap even for the largest launch velocity.
  localparam int unsigned SUM_W = ((H_W > VY_W) ? H_W : VY_W) + 2;
  localparam logic [H_W-1:0] H_MAX = '1;
  localparam logic [D_W-1:0] D_MAX = '1;

  state_e                 state_q, state_d;
  logic signed [VY_W-1:0] vy_q, vy_d;
  logic [H_W-1:0]         height_q, height_d;
  logic [D_W-1:0]         dist_q, dist_d;
  logic                   apex_q, apex_d;
  logic                   land_q, land_d;
`ifdef JUMP_APEX_HOLD_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(APEX_HOLD - 1);
  logic [HOLD_CNT_W-1:0]  hold_q, hold_d;
`endif

  logic                   tick;
  logic                   start_ok;
  logic signed [SUM_W-1:0] h_n, vy_nxt;
  logic                   vy_le0, hn_le0, vyn_le0;

  jump_kinematics_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (start_ok),
    .o_tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    vy_d     = vy_q;
    height_d = height_q;
    dist_d   = dist_q;
    apex_d   = 1'b0;
    land_d   = 1'b0;
    start_ok = 1'b0;
`ifdef JUMP_APEX_HOLD_EN
    hold_d   = hold_q;
`endif

    h_n     = {{(SUM_W-H_W){1'b0}}, height_q} + {{(SUM_W-VY_W){vy_q[VY_W-1]}}, vy_q};
    vy_nxt  = {{(SUM_W-VY_W){vy_q[VY_W-1]}}, vy_q} - SUM_W'(GRAVITY);
    vy_le0  = vy_q[VY_W-1] || (vy_q == '0);
    hn_le0  = h_n[SUM_W-1] || (h_n == '0);
    vyn_le0 = vy_nxt[SUM_W-1] || (vy_nxt == '0);

    if (i_abort) begin
      state_d  = ST_IDLE;
      height_d = '0;
    end else if (i_start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      start_ok = 1'b1;
      state_d  = ST_RISE;
      vy_d     = {1'b0, i_v_init};
      height_d = '0;
      dist_d   = '0;
    end else if (tick) begin
      case (state_q)
        ST_RISE, ST_FALL: begin
          vy_d   = vy_nxt[VY_W-1:0];
          dist_d = D_W'(sat_inc(32'(dist_q), VX, 32'(D_MAX)));
          if (vy_le0 && hn_le0) begin
            height_d = '0;
            land_d   = 1'b1;
            state_d  = ST_DONE;
          end else begin
            // Not landing implies h_n is positive, so any upper bit means overflow.
            height_d = (|h_n[SUM_W-1:H_W]) ? H_MAX : h_n[H_W-1:0];
            if (state_q == ST_RISE && vyn_le0) begin
              apex_d = 1'b1;
`ifdef JUMP_APEX_HOLD_EN
              state_d = ST_HOLD;
              hold_d  = '0;
`else
              state_d = ST_FALL;
`endif
            end
          end
        end
`ifdef JUMP_APEX_HOLD_EN
        ST_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = ST_FALL;
          end else begin
            hold_d = hold_q + HOLD_CNT_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      vy_q     <= '0;
      height_q <= '0;
      dist_q   <= '0;
      apex_q   <= 1'b0;
      land_q   <= 1'b0;
`ifdef JUMP_APEX_HOLD_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      vy_q     <= vy_d;
      height_q <= height_d;
      dist_q   <= dist_d;
      apex_q   <= apex_d;
      land_q   <= land_d;
`ifdef JUMP_APEX_HOLD_EN
      hold_q   <= hold_d;
`endif
    end
  end

  assign o_height = height_q;
  assign o_dist   = dist_q;
  assign o_apex   = apex_q;
  assign o_land   = land_q;
  assign o_busy   = (state_q == ST_RISE) || (state_q == ST_FALL) || (state_q == ST_HOLD);
  assign o_done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_jump_kinematics.sv
// tb/tb_jump_kinematics.sv - randomized and directed bench for jump_kinematics against a tick-level model
module tb_jump_kinematics;

  localparam int V_W  = 11;
  localparam int H_W  = 4;
  localparam int D_W  = 8;
  localparam int G    = 1;
  localparam int VX   = 2;
  localparam int TD   = 4;
  localparam int AH   = 2;
  localparam int HMAX = 15;
  localparam int DMAX = 255;
`ifdef JUMP_APEX_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           i_start = 1'b0;
  logic           i_abort = 1'b0;
  logic [V_W-1:0] i_v_init = '0;
  logic [H_W-1:0] o_height;
  logic [D_W-1:0] o_dist;
  logic           o_busy, o_apex, o_land, o_done;

  int checks = 0;
  int failures = 0;

  int exp_h[$];
  int exp_d[$];
  bit exp_apex[$];
  bit exp_land[$];
  int obs_h[$];
  int land_tick, apex_tick, apex_cnt, max_h;

  jump_kinematics #(
    .V_W(V_W), .H_W(H_W), .D_W(D_W), .GRAVITY(G), .VX(VX), .TICK_DIV(TD), .APEX_HOLD(AH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_v_init(i_v_init),
    .o_height(o_height), .o_dist(o_dist), .o_busy(o_busy), .o_apex(o_apex),
    .o_land(o_land), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Physics per tick with plain integers: phase 1 = rising, 2 = falling, 3 = frozen at apex.
  task automatic model_jump(input int v);
    int h, vy, d, hold, ph, hn, vn, guard;
    bit apex, land;
    h = 0; vy = v; d = 0; hold = 0; ph = 1; guard = 0;
    exp_h.delete(); exp_d.delete(); exp_apex.delete(); exp_land.delete();
    land = 1'b0;
    while (!land && guard < 20000) begin
      apex = 1'b0;
      guard++;
      if (ph == 3) begin
        hold++;
        if (hold == AH) ph = 2;
      end else begin
        hn = h + vy;
        vn = vy - G;
        d = (d + VX > DMAX) ? DMAX : d + VX;
        if (vy <= 0 && hn <= 0) begin
          h = 0;
          land = 1'b1;
        end else begin
          h = (hn > HMAX) ? HMAX : hn;
          if (ph == 1 && vn <= 0) begin
            apex = 1'b1;
            ph = HOLD_EN ? 3 : 2;
            hold = 0;
          end
        end
        vy = vn;
      end
      exp_h.push_back(h); exp_d.push_back(d);
      exp_apex.push_back(apex); exp_land.push_back(land);
    end
  endtask

  task automatic run_jump(input int v, input int poke);
    int n;
    model_jump(v);
    n = exp_h.size();
    obs_h.delete(); land_tick = -1; apex_tick = -1; apex_cnt = 0; max_h = 0;
    @(negedge clk); i_start = 1'b1; i_v_init = V_W'(v);
    @(negedge clk); i_start = 1'b0;
    checks++;
    if (o_height !== '0 || o_dist !== '0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
      failures++;
      $display("FAIL accept v=%0d got h=%0d d=%0d busy=%0b done=%0b exp h=0 d=0 busy=1 done=0",
               v, o_height, o_dist, o_busy, o_done);
    end
    for (int k = 0; k < n; k++) begin
      for (int c = 1; c <= TD; c++) begin
        @(negedge clk);
        i_start = (k == poke && c == 1 && k < n - 1) ? 1'b1 : 1'b0;
        if (i_start) i_v_init = V_W'($urandom_range(1, 60));
        if (c < TD) begin
          checks++;
          if (o_apex !== 1'b0 || o_land !== 1'b0 || o_busy !== 1'b1) begin
            failures++;
            $display("FAIL between_ticks v=%0d tick=%0d got apex=%0b land=%0b busy=%0b exp 0 0 1",
                     v, k + 1, o_apex, o_land, o_busy);
          end
        end
      end
      obs_h.push_back(int'(o_height));
      if (int'(o_height) > max_h) max_h = int'(o_height);
      if (o_apex === 1'b1) begin apex_cnt++; apex_tick = k + 1; end
      if (o_land === 1'b1) land_tick = k + 1;
      checks++;
      if (o_height !== H_W'(exp_h[k]) || o_dist !== D_W'(exp_d[k]) ||
          o_apex !== exp_apex[k] || o_land !== exp_land[k]) begin
        failures++;
        $display("FAIL tick v=%0d tick=%0d got h=%0d d=%0d apex=%0b land=%0b exp h=%0d d=%0d apex=%0b land=%0b",
                 v, k + 1, o_height, o_dist, o_apex, o_land, exp_h[k], exp_d[k], exp_apex[k], exp_land[k]);
      end
      checks++;
      if (o_busy !== (k < n - 1) || o_done !== (k == n - 1)) begin
        failures++;
        $display("FAIL status v=%0d tick=%0d got busy=%0b done=%0b exp busy=%0b done=%0b",
                 v, k + 1, o_busy, o_done, k < n - 1, k == n - 1);
      end
    end
    @(negedge clk);
    checks++;
    if (o_land !== 1'b0 || o_done !== 1'b1 || o_height !== '0 || o_dist !== D_W'(exp_d[n-1])) begin
      failures++;
      $display("FAIL done_hold v=%0d got land=%0b done=%0b h=%0d d=%0d exp land=0 done=1 h=0 d=%0d",
               v, o_land, o_done, o_height, o_dist, exp_d[n-1]);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (o_height !== '0 || o_dist !== '0 || o_busy || o_apex || o_land || o_done) begin
      failures++;
      $display("FAIL reset got h=%0d d=%0d busy=%0b apex=%0b land=%0b done=%0b exp all 0",
               o_height, o_dist, o_busy, o_apex, o_land, o_done);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_case1();
    int golden[$];
    golden = HOLD_EN ? '{3, 5, 6, 6, 6, 6, 5, 3, 0} : '{3, 5, 6, 6, 5, 3, 0};
    run_jump(3, -1);
    checks++;
    if (obs_h.size() != golden.size()) begin
      failures++;
      $display("FAIL case1_len got=%0d exp=%0d", obs_h.size(), golden.size());
    end else begin
      for (int i = 0; i < golden.size(); i++) begin
        checks++;
        if (obs_h[i] != golden[i]) begin
          failures++;
          $display("FAIL case1_height tick=%0d got=%0d exp=%0d", i + 1, obs_h[i], golden[i]);
        end
      end
    end
    checks++;
    if (apex_tick != 3 || apex_cnt != 1 || land_tick != golden.size() || int'(o_dist) != VX * golden.size()) begin
      failures++;
      $display("FAIL case1_events got apex=%0d/%0d land=%0d d=%0d exp apex=3/1 land=%0d d=%0d",
               apex_tick, apex_cnt, land_tick, o_dist, golden.size(), VX * golden.size());
    end
  endtask

  task automatic test_zero_velocity();
    run_jump(0, -1);
    checks++;
    if (land_tick != 1 || apex_cnt != 0 || o_height !== '0 || int'(o_dist) != VX) begin
      failures++;
      $display("FAIL zero_v got land=%0d apex_cnt=%0d h=%0d d=%0d exp land=1 apex_cnt=0 h=0 d=%0d",
               land_tick, apex_cnt, o_height, o_dist, VX);
    end
  endtask

  task automatic test_clamp();
    run_jump(20, -1);
    checks++;
    if (max_h != HMAX || land_tick < 0 || apex_cnt != 1) begin
      failures++;
      $display("FAIL clamp got max_h=%0d land=%0d apex_cnt=%0d exp max_h=%0d land>0 apex_cnt=1",
               max_h, land_tick, apex_cnt, HMAX);
    end
  endtask

  task automatic test_abort();
    bit bad;
    @(negedge clk); i_start = 1'b1; i_v_init = V_W'(3);
    @(negedge clk); i_start = 1'b0;
    repeat (2 * TD) @(negedge clk);
    checks++;
    if (o_height !== H_W'(5) || o_dist !== D_W'(4)) begin
      failures++;
      $display("FAIL abort_pre got h=%0d d=%0d exp h=5 d=4", o_height, o_dist);
    end
    i_abort = 1'b1; i_start = 1'b1; i_v_init = V_W'(9);
    @(negedge clk); i_abort = 1'b0; i_start = 1'b0;
    checks++;
    if (o_height !== '0 || o_dist !== D_W'(4) || o_busy || o_done || o_land) begin
      failures++;
      $display("FAIL abort got h=%0d d=%0d busy=%0b done=%0b land=%0b exp h=0 d=4 busy=0 done=0 land=0",
               o_height, o_dist, o_busy, o_done, o_land);
    end
    bad = 1'b0;
    repeat (12 * TD) begin
      @(negedge clk);
      if (o_land || o_done || o_busy || o_dist !== D_W'(4) || o_height !== '0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL abort_idle got activity after abort exp quiet idle d=4");
    end
  endtask

  task automatic test_back_to_back();
    run_jump(5, 2);
    run_jump(7, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) run_jump(int'($urandom_range(0, 40)), int'($urandom_range(0, 3)));
    run_jump(150, -1);
    checks++;
    if (o_dist !== D_W'(DMAX)) begin
      failures++;
      $display("FAIL dist_sat got=%0d exp=%0d", o_dist, DMAX);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk); i_start = 1'b1; i_v_init = V_W'(3);
    @(negedge clk); i_start = 1'b0;
    repeat (6 * TD) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_height !== '0 || o_dist !== '0 || o_busy || o_apex || o_land || o_done) begin
      failures++;
      $display("FAIL async_reset got h=%0d d=%0d busy=%0b apex=%0b land=%0b done=%0b exp all 0",
               o_height, o_dist, o_busy, o_apex, o_land, o_done);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3 * TD) @(negedge clk);
    checks++;
    if (o_busy || o_done || o_height !== '0 || o_dist !== '0) begin
      failures++;
      $display("FAIL post_reset got busy=%0b done=%0b h=%0d d=%0d exp idle zeros",
               o_busy, o_done, o_height, o_dist);
    end
  endtask

  initial begin
    test_reset();
    test_case1();
    test_zero_velocity();
    test_clamp();
    test_abort();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
